// File: rtl/and_sched_pkg.sv
// Shared types and helpers for the round-robin AND scheduler.
// Holds the FSM state encoding and the id-width helper.
package and_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } t_sched_state;

  // A single requester still needs a 1-bit id field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/and1.sv
// Plain bitwise-AND datapath shared by all requesters.
module and1 #(
  parameter int G_WIDTH = 8
) (
  input  logic [G_WIDTH-1:0] a,
  input  logic [G_WIDTH-1:0] b,
  output logic [G_WIDTH-1:0] c
);

  assign c = a & b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_id and
// wraps, and the first set request wins.
module rr_arbiter
  import and_sched_pkg::*;
#(
  parameter  int G_NUM_REQ = 4,
  localparam int C_ID_W    = clog2_min1(G_NUM_REQ)
) (
  input  logic [G_NUM_REQ-1:0] req,
  input  logic [C_ID_W-1:0]    last_id,
  input  logic                 en,
  output logic [G_NUM_REQ-1:0] gnt,
  output logic [C_ID_W-1:0]    winner
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= G_NUM_REQ; k++) begin
      idx = int'(last_id) + k;
      if (idx >= G_NUM_REQ) idx = idx - G_NUM_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = C_ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/and_rr_scheduler.sv
// Round-robin scheduler sharing one and1 datapath among G_NUM_REQ requesters;
// results return over a valid/ready channel tagged with the requester id.
module and_rr_scheduler
  import and_sched_pkg::*;
#(
  parameter  int G_WIDTH   = 8,
  parameter  int G_NUM_REQ = 4,
  localparam int C_ID_W    = clog2_min1(G_NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [G_NUM_REQ-1:0]         req,
  input  logic [G_NUM_REQ*G_WIDTH-1:0] a,
  input  logic [G_NUM_REQ*G_WIDTH-1:0] b,
  output logic [G_NUM_REQ-1:0]         gnt,
  output logic [G_WIDTH-1:0]           c,
  output logic [C_ID_W-1:0]            c_id,
  output logic                         c_valid,
  input  logic                         c_ready
);

  t_sched_state         state, state_nxt;
  logic                 arb_en;
  logic                 take;
  logic [G_NUM_REQ-1:0] arb_gnt;
  logic [C_ID_W-1:0]    winner;
  logic [C_ID_W-1:0]    last_id;
  logic [C_ID_W-1:0]    op_id;
  logic [G_WIDTH-1:0]   op_a, op_b;
  logic [G_WIDTH-1:0]   sel_a, sel_b;
  logic [G_WIDTH-1:0]   and_c;

  // Grants only when the result slot is free or being drained this cycle;
  // gated by rst so nothing is accepted while reset is held.
  assign arb_en = !rst && ((state == IDLE) || (state == RESP && c_ready));
  assign take   = |arb_gnt;
  assign gnt    = arb_gnt;

  rr_arbiter #(
    .G_NUM_REQ(G_NUM_REQ)
  ) u_arb (
    .req    (req),
    .last_id(last_id),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .winner (winner)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < G_NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_a = sel_a | a[i*G_WIDTH +: G_WIDTH];
        sel_b = sel_b | b[i*G_WIDTH +: G_WIDTH];
      end
    end
  end

  and1 #(
    .G_WIDTH(G_WIDTH)
  ) u_and1 (
    .a(op_a),
    .b(op_b),
    .c(and_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (c_ready) state_nxt = take ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      op_id   <= '0;
      last_id <= C_ID_W'(G_NUM_REQ - 1);
      c       <= '0;
      c_id    <= '0;
      c_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_a    <= sel_a;
        op_b    <= sel_b;
        op_id   <= winner;
        last_id <= winner;
      end
      if (state == EXEC) begin
        c       <= and_c;
        c_id    <= op_id;
        c_valid <= 1'b1;
      end else if (state == RESP && c_ready) begin
        c_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_and_rr_scheduler.sv
// Self-checking bench for and_rr_scheduler: directed scenarios plus a random
// run against a transaction-level model; a second instance covers G_NUM_REQ=1.
module tb_and_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a, b;
  logic [3:0]  gnt;
  logic [7:0]  c;
  logic [1:0]  c_id;
  logic        c_valid;
  logic        c_ready;

  logic [0:0]  req1;
  logic [15:0] a1, b1;
  logic [0:0]  gnt1;
  logic [15:0] c1;
  logic [0:0]  c1_id;
  logic        c1_valid;
  logic        c1_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_rr_scheduler #(.G_WIDTH(8), .G_NUM_REQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .gnt(gnt),
    .c(c), .c_id(c_id), .c_valid(c_valid), .c_ready(c_ready)
  );

  and_rr_scheduler #(.G_WIDTH(16), .G_NUM_REQ(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .a(a1), .b(b1), .gnt(gnt1),
    .c(c1), .c_id(c1_id), .c_valid(c1_valid), .c_ready(c1_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Round-robin reference: first set request scanning from last+1 with wrap.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; req1 = 1'b1; c_ready = 1'b0;
    #2;
    checks += 5;
    if (gnt !== 4'h0) begin failures++; $display("FAIL reset_gnt: got %h want 0", gnt); end
    if (c_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", c_valid); end
    if (c !== 8'h00) begin failures++; $display("FAIL reset_c: got %h want 00", c); end
    if (c_id !== 2'd0) begin failures++; $display("FAIL reset_cid: got %0d want 0", c_id); end
    if (gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
    @(posedge clk);
    #1 rst = 1'b0; req = 4'h0; req1 = 1'b0;
  endtask

  task automatic test_single();
    req = 4'b0001; a = 32'h0000_00F0; b = 32'h0000_003C; c_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    step();
    req = 4'b0000;
    @(negedge clk);
    checks += 2;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL single_exec_gnt: got %b want 0000", gnt); end
    if (c_valid !== 1'b0) begin failures++; $display("FAIL single_exec_valid: got %b want 0", c_valid); end
    step();
    @(negedge clk);
    checks += 3;
    if (c_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", c_valid); end
    if (c !== 8'h30) begin failures++; $display("FAIL single_c: got %h want 30", c); end
    if (c_id !== 2'd0) begin failures++; $display("FAIL single_cid: got %0d want 0", c_id); end
    step();
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (c_valid !== 1'b0) begin failures++; $display("FAIL single_drain: got %b want 0", c_valid); end
  endtask

  task automatic test_all_four();
    pulse_reset();
    req = 4'hF; a = 32'hFFFF_FFFF; c_ready = 1'b1;
    for (int i = 0; i < 4; i++) b[i*8 +: 8] = 8'(i + 1);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL all_first_gnt: got %b want 0001", gnt); end
    step(); step();
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      checks += 4;
      if (c_valid !== 1'b1) begin failures++; $display("FAIL all_valid[%0d]: got %b want 1", g, c_valid); end
      if (c !== 8'(g + 1)) begin failures++; $display("FAIL all_c[%0d]: got %h want %h", g, c, 8'(g + 1)); end
      if (c_id !== 2'(g)) begin failures++; $display("FAIL all_cid[%0d]: got %0d want %0d", g, c_id, g); end
      if (gnt !== 4'(1 << ((g + 1) % 4))) begin
        failures++; $display("FAIL all_gnt[%0d]: got %b want %b", g, gnt, 4'(1 << ((g + 1) % 4)));
      end
      if (g == 3) req = 4'h0;
      step(); step();
    end
    c_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    pulse_reset();
    req = 4'b0001; a = 32'h0000_5A0F; b = 32'h0000_F0FF; c_ready = 1'b0;
    step();
    req = 4'b0000;
    step();
    req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks += 4;
      if (c_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b want 1", k, c_valid); end
      if (c !== 8'h0F) begin failures++; $display("FAIL bp_c[%0d]: got %h want 0f", k, c); end
      if (c_id !== 2'd0) begin failures++; $display("FAIL bp_cid[%0d]: got %0d want 0", k, c_id); end
      if (gnt !== 4'b0000) begin failures++; $display("FAIL bp_gnt[%0d]: got %b want 0000", k, gnt); end
      step();
    end
    c_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL bp_release_gnt: got %b want 0010", gnt); end
    step();
    req = 4'b0000; c_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (c_valid !== 1'b0) begin failures++; $display("FAIL bp_exec_valid: got %b want 0", c_valid); end
    step();
    @(negedge clk);
    checks += 3;
    if (c_valid !== 1'b1) begin failures++; $display("FAIL bp_new_valid: got %b want 1", c_valid); end
    if (c !== 8'h50) begin failures++; $display("FAIL bp_new_c: got %h want 50", c); end
    if (c_id !== 2'd1) begin failures++; $display("FAIL bp_new_cid: got %0d want 1", c_id); end
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
  endtask

  task automatic test_fairness();
    int last = 1;
    int prev = -1;
    int exp_id;
    req = 4'b1010; a = 32'hFFFF_FFFF; b = 32'h8040_2010; c_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      exp_id = rr_pick(req, last);
      @(negedge clk);
      checks += 2;
      if (gnt !== 4'(1 << exp_id)) begin failures++; $display("FAIL fair_gnt[%0d]: got %b want %b", n, gnt, 4'(1 << exp_id)); end
      if (exp_id == prev) begin failures++; $display("FAIL fair_repeat[%0d]: got %0d want not %0d", n, exp_id, prev); end
      prev = exp_id;
      last = exp_id;
      step(); step();
    end
    req = 4'b0000;
    step();
    c_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    req = 4'b0001; a = 32'h0000_00FF; b = 32'h0000_0077; c_ready = 1'b0;
    step();
    req = 4'b0101;
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (c_valid !== 1'b0) begin failures++; $display("FAIL rst_exec_valid: got %b want 0", c_valid); end
    if (c !== 8'h00) begin failures++; $display("FAIL rst_exec_c: got %h want 00", c); end
    if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_exec_gnt: got %b want 0000", gnt); end
    step(); step();
    @(negedge clk);
    checks++;
    if (c_valid !== 1'b0) begin failures++; $display("FAIL rst_held_valid: got %b want 0", c_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL rst_release_gnt: got %b want 0001", gnt); end
    step();
    req = 4'b0000;
    step();
    @(negedge clk);
    checks += 2;
    if (c !== 8'h77) begin failures++; $display("FAIL rst_after_c: got %h want 77", c); end
    if (c_id !== 2'd0) begin failures++; $display("FAIL rst_after_cid: got %0d want 0", c_id); end
    c_ready = 1'b1;
    step();
    c_ready = 1'b0;
  endtask

  // Transaction-level model: one operand slot, one result slot, round-robin pointer.
  task automatic test_random();
    bit        m_exec, m_valid;
    logic [7:0] m_op, m_c;
    int        m_opid, m_id, m_last, pick;
    bit        can;
    logic [3:0] exp_gnt;
    pulse_reset();
    m_exec = 0; m_valid = 0; m_op = '0; m_c = '0; m_opid = 0; m_id = 0; m_last = 3;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req     = 4'($urandom_range(0, 15));
      a       = $urandom;
      b       = $urandom;
      c_ready = ($urandom_range(0, 3) != 0);
      can     = !m_exec && (!m_valid || c_ready);
      pick    = can ? rr_pick(req, m_last) : -1;
      exp_gnt = (pick >= 0) ? 4'(1 << pick) : 4'h0;
      @(negedge clk);
      checks += 2;
      if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt[%0d]: got %b want %b", cyc, gnt, exp_gnt); end
      if (c_valid !== m_valid) begin failures++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, c_valid, m_valid); end
      if (m_valid) begin
        checks += 2;
        if (c !== m_c) begin failures++; $display("FAIL rand_c[%0d]: got %h want %h", cyc, c, m_c); end
        if (c_id !== 2'(m_id)) begin failures++; $display("FAIL rand_cid[%0d]: got %0d want %0d", cyc, c_id, m_id); end
      end
      if (m_exec) begin
        m_valid = 1; m_c = m_op; m_id = m_opid; m_exec = 0;
      end else if (m_valid && c_ready) begin
        m_valid = 0;
      end
      if (pick >= 0) begin
        m_exec = 1; m_op = a[pick*8 +: 8] & b[pick*8 +: 8]; m_opid = pick; m_last = pick;
      end
      step();
    end
    req = 4'h0; c_ready = 1'b1;
    step(); step(); step();
    c_ready = 1'b0;
  endtask

  task automatic test_single_requester_cfg();
    bit exp_g, exp_v;
    req1 = 1'b1; a1 = 16'hAAAA; b1 = 16'hFFFF; c1_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0);
      exp_v = (k >= 2) && (k % 2 == 0);
      @(negedge clk);
      checks += 2;
      if (gnt1 !== exp_g) begin failures++; $display("FAIL one_gnt[%0d]: got %b want %b", k, gnt1, exp_g); end
      if (c1_valid !== exp_v) begin failures++; $display("FAIL one_valid[%0d]: got %b want %b", k, c1_valid, exp_v); end
      if (exp_v) begin
        checks += 2;
        if (c1 !== 16'hAAAA) begin failures++; $display("FAIL one_c[%0d]: got %h want aaaa", k, c1); end
        if (c1_id !== 1'b0) begin failures++; $display("FAIL one_cid[%0d]: got %0d want 0", k, c1_id); end
      end
      step();
    end
    req1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; a = '0; b = '0; c_ready = 1'b0;
    req1 = '0; a1 = '0; b1 = '0; c1_ready = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_reset_mid_exec();
    test_random();
    test_single_requester_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
